// File: rtl/alu_muldiv_unit.sv
// -----------------------------------------------------------------------------
// alu_muldiv_unit
//
// Handshaked execute unit for the EX stage. Base ALU ops finish in a single
// cycle. MUL/MULHU and DIV/DIVU/REM/REMU iterate one bit per cycle: shift-add
// for multiply, restoring subtract for divide. The result and its flags are
// registered together and held until the consumer takes them.
//
// Ports
//   clk          in   1      single clock, all state on the rising edge
//   rst_n        in   1      asynchronous, active-low reset
//   in_valid     in   1      operands/op valid; accepted when in_valid & in_ready
//   in_ready     out  1      unit idle and able to accept
//   src_a        in   WIDTH  operand A
//   src_b        in   WIDTH  operand B
//   alu_control  in   4      op select
//   kill         in   1      synchronous abort of an in-flight op
//   out_valid    out  1      alu_result/flags valid, held until out_ready
//   out_ready    in   1      consumer takes the result
//   alu_result   out  WIDTH  registered result
//   zf           out  1      alu_result == 0
//   sf           out  1      alu_result[WIDTH-1]
//   dz           out  1      divide/remainder by zero occurred
//
// Op encoding
//   0000 ADD  0001 SLL  0010 SUB  0011 SRA  0100 XOR  0101 SRL  0110 OR
//   0111 AND  1010/1011 reserved (result 0)
//   1000 MUL  1001 MULHU  1100 DIVU  1101 REMU  1110 DIV  1111 REM
// -----------------------------------------------------------------------------
module alu_muldiv_unit #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [3:0]       alu_control,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zf,
    output logic             sf,
    output logic             dz
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [SHW:0] CNT_LOAD = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    state_t state;
    state_t next_state;

    // Iteration state. acc holds the product high half or the partial
    // remainder; mq holds the multiplier/product low half or the
    // dividend/quotient; opnd holds the multiplicand or the divisor.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] opnd;
    logic [3:0]       op_q;
    logic [SHW:0]     counter;
    logic             neg_q;
    logic             neg_r;
    logic             dz_pend;

    logic             accept;
    logic             iter_op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] base_result;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             signed_div;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shifted;
    logic [WIDTH+1:0] div_diff;
    logic             div_borrow;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_mq;
    logic [WIDTH-1:0] final_result;

    // Kill wins over a same-cycle accept, so it also masks in_valid in IDLE.
    assign accept  = in_valid && (state == IDLE) && !kill;
    assign iter_op = (alu_control == 4'b1000) || (alu_control == 4'b1001) ||
                     (alu_control[3:2] == 2'b11);
    assign shamt   = src_b[SHW-1:0];

    // Single-cycle ALU result, registered directly at the accepting edge.
    always_comb begin
        base_result = '0;
        case (alu_control)
            4'b0000: base_result = src_a + src_b;
            4'b0001: base_result = src_a << shamt;
            4'b0010: base_result = src_a - src_b;
            4'b0011: base_result = $signed(src_a) >>> shamt;
            4'b0100: base_result = src_a ^ src_b;
            4'b0101: base_result = src_a >> shamt;
            4'b0110: base_result = src_a | src_b;
            4'b0111: base_result = src_a & src_b;
            default: base_result = '0;
        endcase
    end

    // Signed divides iterate on magnitudes; the signs are fixed up at the end.
    always_comb begin
        signed_div = alu_control[1];
        a_neg      = src_a[WIDTH-1];
        b_neg      = src_b[WIDTH-1];
        abs_a      = (signed_div && a_neg) ? (~src_a + 1'b1) : src_a;
        abs_b      = (signed_div && b_neg) ? (~src_b + 1'b1) : src_b;
    end

    // One iteration step. The divide difference carries two extra bits so a
    // zero divisor never looks like a borrow: the quotient fills with ones and
    // the remainder shifts back out to the dividend, which is exactly the
    // divide-by-zero result without any special casing.
    always_comb begin
        mul_sum     = {1'b0, acc} + {1'b0, (mq[0] ? opnd : '0)};
        div_shifted = {acc, mq[WIDTH-1]};
        div_diff    = {1'b0, div_shifted} - {2'b00, opnd};
        div_borrow  = div_diff[WIDTH+1];
        if (op_q[2]) begin
            step_acc = div_borrow ? div_shifted[WIDTH-1:0] : div_diff[WIDTH-1:0];
            step_mq  = {mq[WIDTH-2:0], ~div_borrow};
        end else begin
            step_acc = mul_sum[WIDTH:1];
            step_mq  = {mul_sum[0], mq[WIDTH-1:1]};
        end
    end

    // Result selection applied together with the last iteration step.
    always_comb begin
        final_result = '0;
        case (op_q)
            4'b1000: final_result = step_mq;
            4'b1001: final_result = step_acc;
            4'b1100: final_result = step_mq;
            4'b1101: final_result = step_acc;
            4'b1110: final_result = neg_q ? (~step_mq + 1'b1) : step_mq;
            4'b1111: final_result = neg_r ? (~step_acc + 1'b1) : step_acc;
            default: final_result = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = iter_op ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (kill) begin
                    next_state = IDLE;
                end else if (counter == CNT_ONE) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (kill || out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs follow the state directly.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: operand latch at accept, iteration in BUSY, result/flag
    // registers. A kill leaves the previous result untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            mq         <= '0;
            opnd       <= '0;
            op_q       <= '0;
            counter    <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            dz_pend    <= 1'b0;
            alu_result <= '0;
            zf         <= 1'b1;
            sf         <= 1'b0;
            dz         <= 1'b0;
        end else if (accept) begin
            op_q <= alu_control;
            dz   <= 1'b0;
            if (iter_op) begin
                counter <= CNT_LOAD;
                acc     <= '0;
                if (alu_control[2]) begin
                    mq      <= abs_a;
                    opnd    <= abs_b;
                    neg_q   <= signed_div && (a_neg ^ b_neg) && (src_b != '0);
                    neg_r   <= signed_div && a_neg;
                    dz_pend <= (src_b == '0);
                end else begin
                    mq      <= src_b;
                    opnd    <= src_a;
                    neg_q   <= 1'b0;
                    neg_r   <= 1'b0;
                    dz_pend <= 1'b0;
                end
            end else begin
                alu_result <= base_result;
                zf         <= (base_result == '0);
                sf         <= base_result[WIDTH-1];
            end
        end else if ((state == BUSY) && !kill) begin
            acc     <= step_acc;
            mq      <= step_mq;
            counter <= counter - CNT_ONE;
            if (counter == CNT_ONE) begin
                alu_result <= final_result;
                zf         <= (final_result == '0);
                sf         <= final_result[WIDTH-1];
                dz         <= dz_pend;
            end
        end
    end

endmodule
